clusterv_wb_sram_bank_ctrl: RTL and testbench
=============================================

CLUSTERV_WB_SRAM_BANK_CTRL -- requirements
Module: clusterv_wb_sram_bank_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 9, word-address width of each SRAM bank (512 words).
REQ-002 Parameter NUM_BANKS, default 4, number of SRAM banks; SHALL be a power of two, 2..8.
REQ-003 clock  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 t_adr  in  32  Wishbone byte address; t_dat_w  in  32  write data; t_dat_r  out  32  read data.
REQ-006 t_cyc, t_stb, t_we  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-007 t_sel  in  4  byte lanes; t_ack  out  1  acknowledge; t_err  out  1  error.
REQ-008 t_tgd_w  in  1, t_tga  in  1, t_tgc  in  4  Wishbone tags, accepted and ignored; t_tgd_r  out  1  SHALL be constant 0.
REQ-009 sram_csb  out  NUM_BANKS  per-bank chip select, active low.
REQ-010 sram_web  out  1  shared write-enable, active low; sram_wmask  out  4  shared byte mask.
REQ-011 sram_addr  out  ADDR_BITS  shared word address; sram_dat_w  out  32  shared write data.
REQ-012 sram_dat_r  in  32*NUM_BANKS  per-bank read data; bank b occupies bits [32*b+:32].

Function
REQ-013 Request: t_cyc & t_stb high while the FSM is in IDLE.
REQ-014 Word address SHALL be t_adr[ADDR_BITS+1:2]; bank index SHALL be t_adr[ADDR_BITS+1+log2(NUM_BANKS):ADDR_BITS+2]; the remaining upper bits and t_adr[1:0] SHALL be ignored.
REQ-015 The SRAM outputs SHALL be combinational from the request in IDLE, so the macro samples the request on the edge that ends the request cycle.
REQ-016 In IDLE with a request, the selected bank's sram_csb bit SHALL be 0 and all other bits 1; sram_web = ~t_we; sram_addr = word address; sram_dat_w = t_dat_w.
REQ-017 sram_wmask SHALL equal t_sel for writes and 4'hF for reads.
REQ-018 A write with t_sel == 0 SHALL assert no csb and SHALL still be acknowledged.
REQ-019 In all states other than IDLE-with-request, sram_csb SHALL be all-ones and sram_web SHALL be 1.
REQ-020 FSM states: IDLE, RD_CAP, ACK.
REQ-021 IDLE -> ACK on a write request; IDLE -> RD_CAP on a read request; IDLE -> IDLE otherwise.
REQ-022 RD_CAP SHALL register the selected bank's sram_dat_r slice into t_dat_r, then go to ACK; the bank index SHALL be latched at request time.
REQ-023 ACK -> IDLE unconditionally.
REQ-024 t_ack = (state == ACK) & t_cyc, high for exactly one cycle per transfer.
REQ-025 Latency: a write is acknowledged 1 cycle after the request cycle; a read is acknowledged 2 cycles after it.
REQ-026 t_dat_r SHALL hold its last captured value until the next RD_CAP; writes SHALL NOT alter it.
REQ-027 Back-to-back transfers: a request present in the IDLE cycle after ACK SHALL be accepted immediately, giving 2-cycle write and 3-cycle read throughput.
REQ-028 Abort: if t_cyc drops in RD_CAP or ACK, the FSM SHALL still complete to IDLE with no ack; an in-flight SRAM write is not cancelled.
REQ-029 t_err SHALL be constant 0.

Reset
REQ-030 While reset is high: state = IDLE, t_ack = 0, t_dat_r = 0, latched bank = 0, sram_csb all-ones, sram_web = 1, regardless of t_cyc/t_stb.
REQ-031 Reset asserted in RD_CAP or ACK SHALL abandon the transfer with no ack; the first request after reset deasserts SHALL be accepted in its first cycle.

Verification
REQ-032 Write adr 0x0000_0804, dat 0xDEADBEEF, sel 0xF -> bank 1 csb low in the request cycle, addr 1, wmask 0xF, web 0; t_ack exactly 1 cycle later.
REQ-033 Read adr 0x0000_0804 with bank 1 model returning 0xDEADBEEF -> t_ack 2 cycles after request, t_dat_r 0xDEADBEEF; all other csb bits high throughout.
REQ-034 Byte write sel 0x4, dat 0x00AB0000, to adr 0x1FFC -> bank 3 addr 511, wmask 0x4; readback gives the old word with byte 2 = 0xAB (wrap-boundary address).
REQ-035 Stb held high across 3 consecutive reads to banks 0, 2, 3 -> acks at cycles 2, 5, 8 with the correct per-bank data.
REQ-036 Write with sel 0x0 -> no csb asserted, t_ack after 1 cycle.
REQ-037 Read with reset pulsed in RD_CAP -> no t_ack, t_dat_r = 0, next request serviced normally; t_cyc dropped in ACK -> t_ack stays 0, FSM returns to IDLE.

Source files
------------

// File: rtl/clusterv_wb_sram_bank_ctrl.sv
// Wishbone slave fronting NUM_BANKS single-port SRAM macros; one bank per request, address-interleaved on the high bits.
// Latency: write ack 1 cycle after request, read ack 2 cycles after; no waitstates otherwise, t_err never raised.
module clusterv_wb_sram_bank_ctrl #(
    parameter int ADDR_BITS = 9,
    parameter int NUM_BANKS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               t_adr,
    input  logic [31:0]               t_dat_w,
    output logic [31:0]               t_dat_r,
    input  logic                      t_cyc,
    input  logic                      t_stb,
    input  logic                      t_we,
    input  logic [3:0]                t_sel,
    output logic                      t_ack,
    output logic                      t_err,
    input  logic                      t_tgd_w,
    input  logic                      t_tga,
    input  logic [3:0]                t_tgc,
    output logic                      t_tgd_r,
    output logic [NUM_BANKS-1:0]      sram_csb,
    output logic                      sram_web,
    output logic [3:0]                sram_wmask,
    output logic [ADDR_BITS-1:0]      sram_addr,
    output logic [31:0]               sram_dat_w,
    input  logic [32*NUM_BANKS-1:0]   sram_dat_r
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_LSB  = ADDR_BITS + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CAP = 2'd1,
        ACK    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [BANK_BITS-1:0]   bank_q, bank_d;
    logic [31:0]            t_dat_r_q, t_dat_r_d;
    logic [BANK_BITS-1:0]   req_bank;
    logic                   req;
    logic                   unused_inputs;

    assign req_bank = t_adr[BANK_LSB +: BANK_BITS];
    assign req      = (state_q == IDLE) & t_cyc & t_stb & ~reset;

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        t_dat_r_d = t_dat_r_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    bank_d  = req_bank;
                    state_d = t_we ? ACK : RD_CAP;
                end
            end
            RD_CAP: begin
                // Macro output is valid after the request edge and held while csb stays high.
                t_dat_r_d = sram_dat_r[{bank_q, 5'd0} +: 32];
                state_d   = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            t_dat_r_q <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            t_dat_r_q <= t_dat_r_d;
        end
    end

    // Macro strobes are driven straight from the bus so the macro samples on the edge ending the request cycle.
    always_comb begin
        sram_csb = '1;
        sram_web = 1'b1;
        if (req) begin
            sram_web = ~t_we;
            if (!(t_we && (t_sel == 4'h0))) begin
                sram_csb[req_bank] = 1'b0;
            end
        end
    end

    assign sram_wmask = t_we ? t_sel : 4'hF;
    assign sram_addr  = t_adr[ADDR_BITS+1:2];
    assign sram_dat_w = t_dat_w;

    assign t_ack   = (state_q == ACK) & t_cyc & ~reset;
    assign t_dat_r = reset ? 32'h0 : t_dat_r_q;
    assign t_err   = 1'b0;
    assign t_tgd_r = 1'b0;

    assign unused_inputs = ^{t_tgd_w, t_tga, t_tgc, t_adr[31:BANK_LSB+BANK_BITS], t_adr[1:0]};

endmodule

// File: tb/tb_clusterv_wb_sram_bank_ctrl.sv
// Bench for clusterv_wb_sram_bank_ctrl: behavioural SRAM macros on the pins, transaction-level
// reference memory, directed corner cases followed by randomized Wishbone traffic.
module tb_clusterv_wb_sram_bank_ctrl;
    localparam int AB    = 9;
    localparam int NB    = 4;
    localparam int WORDS = 1 << AB;

    logic                 clock;
    logic                 reset;
    logic [31:0]          t_adr, t_dat_w, t_dat_r;
    logic                 t_cyc, t_stb, t_we;
    logic [3:0]           t_sel;
    logic                 t_ack, t_err;
    logic                 t_tgd_w, t_tga;
    logic [3:0]           t_tgc;
    logic                 t_tgd_r;
    logic [NB-1:0]        sram_csb;
    logic                 sram_web;
    logic [3:0]           sram_wmask;
    logic [AB-1:0]        sram_addr;
    logic [31:0]          sram_dat_w;
    logic [32*NB-1:0]     sram_dat_r;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] ref_mem [NB][WORDS];
    logic [31:0] last_rd;

    clusterv_wb_sram_bank_ctrl #(.ADDR_BITS(AB), .NUM_BANKS(NB)) dut (
        .clock(clock), .reset(reset),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
        .t_ack(t_ack), .t_err(t_err),
        .t_tgd_w(t_tgd_w), .t_tga(t_tga), .t_tgc(t_tgc), .t_tgd_r(t_tgd_r),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_dat_w(sram_dat_w), .sram_dat_r(sram_dat_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] init_word(input int b, input int w);
        return 32'((b * WORDS + w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural single-port macros: sample on the rising edge, read data held while deselected.
    logic [31:0] env_mem [NB][WORDS];
    logic [31:0] env_dout [NB];
    bit          env_ready = 1'b0;

    always @(posedge clock) begin
        if (!env_ready) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < WORDS; w++)
                    env_mem[b][w] <= init_word(b, w);
            for (int b = 0; b < NB; b++) env_dout[b] <= 32'h0;
            env_ready <= 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (!sram_csb[b]) begin
                    if (!sram_web) begin
                        for (int j = 0; j < 4; j++)
                            if (sram_wmask[j]) env_mem[b][sram_addr][8*j +: 8] <= sram_dat_w[8*j +: 8];
                    end else begin
                        env_dout[b] <= env_mem[b][sram_addr];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_dout
        assign sram_dat_r[32*g +: 32] = env_dout[g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bus untouched just after the edge that ends the ACK cycle.
    task automatic xfer(input logic we_i, input logic [31:0] adr_i, input logic [31:0] dat_i,
                        input logic [3:0] sel_i, output int req_cyc, output int ack_cyc);
        int b, w, lat;
        bit got;
        logic [NB-1:0] exp_csb;
        logic [31:0] exp_rd;
        b = int'((adr_i >> (AB + 2)) % NB);
        w = int'((adr_i >> 2) % WORDS);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we_i;
        t_adr = adr_i; t_dat_w = dat_i; t_sel = sel_i;
        t_tga = 1'($urandom); t_tgd_w = 1'($urandom); t_tgc = 4'($urandom);
        exp_csb = '1;
        if (!(we_i && sel_i == 4'h0)) exp_csb[b] = 1'b0;
        @(negedge clock);
        req_cyc = cycle;
        check("req_csb", 32'(sram_csb), 32'(exp_csb));
        check("req_web", 32'(sram_web), 32'(!we_i));
        check("req_addr", 32'(sram_addr), 32'(w));
        check("req_wmask", 32'(sram_wmask), we_i ? 32'(sel_i) : 32'hF);
        if (we_i) check("req_dat_w", sram_dat_w, dat_i);
        check("req_ack", 32'(t_ack), 32'h0);
        exp_rd = ref_mem[b][w];
        if (we_i)
            for (int j = 0; j < 4; j++)
                if (sel_i[j]) ref_mem[b][w][8*j +: 8] = dat_i[8*j +: 8];
        lat = 0;
        got = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clock);
            lat++;
            check("busy_csb", 32'(sram_csb), 32'(4'hF));
            if (t_ack) got = 1'b1;
        end
        ack_cyc = cycle;
        check("latency", 32'(lat), we_i ? 32'd1 : 32'd2);
        check("t_err", 32'(t_err), 32'h0);
        check("t_tgd_r", 32'(t_tgd_r), 32'h0);
        if (!we_i) last_rd = exp_rd;
        check(we_i ? "dat_r_hold" : "rd_data", t_dat_r, last_rd);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        t_cyc = 1'b0; t_stb = 1'b0;
        repeat (n) begin
            @(negedge clock);
            check("idle_ack", 32'(t_ack), 32'h0);
            check("idle_csb", 32'(sram_csb), 32'(4'hF));
            @(posedge clock);
            #1;
        end
    endtask

    int rc, ac, s0;
    logic [31:0] radr;

    initial begin
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < WORDS; w++)
                ref_mem[b][w] = init_word(b, w);
        last_rd = 32'h0;
        reset = 1'b1;
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_sel = 4'hF;
        t_adr = 32'h0000_0804; t_dat_w = 32'h1234_5678;
        t_tgd_w = 1'b0; t_tga = 1'b0; t_tgc = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_ack", 32'(t_ack), 32'h0);
        check("rst_csb", 32'(sram_csb), 32'(4'hF));
        check("rst_web", 32'(sram_web), 32'h1);
        check("rst_dat_r", t_dat_r, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Request presented in the very first cycle out of reset.
        xfer(1'b1, 32'h0000_0804, 32'hDEADBEEF, 4'hF, rc, ac);
        idle(1);
        xfer(1'b0, 32'h0000_0804, 32'h0, 4'h0, rc, ac);
        check("rd_deadbeef", t_dat_r, 32'hDEADBEEF);
        idle(1);

        xfer(1'b1, 32'h0000_1FFC, 32'h00AB_0000, 4'h4, rc, ac);
        idle(2);
        xfer(1'b0, 32'h0000_1FFC, 32'h0, 4'h0, rc, ac);
        check("wrap_byte2", 32'(t_dat_r[23:16]), 32'hAB);
        check("wrap_byte0", 32'(t_dat_r[7:0]), 32'(init_word(3, 511) & 32'hFF));
        idle(1);

        xfer(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h0, rc, ac);
        idle(1);

        // Strobe held across three reads to banks 0, 2, 3.
        xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, s0, ac);
        check("b2b_ack0", 32'(ac - s0), 32'd2);
        xfer(1'b0, 32'h0000_1020, 32'h0, 4'h0, rc, ac);
        check("b2b_ack1", 32'(ac - s0), 32'd5);
        xfer(1'b0, 32'h0000_1840, 32'h0, 4'h0, rc, ac);
        check("b2b_ack2", 32'(ac - s0), 32'd8);
        idle(1);

        // Reset in RD_CAP abandons the read.
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h0000_0804; t_sel = 4'hF;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rdcap_rst_ack", 32'(t_ack), 32'h0);
        check("rdcap_rst_csb", 32'(sram_csb), 32'(4'hF));
        check("rdcap_rst_web", 32'(sram_web), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        last_rd = 32'h0;
        t_cyc = 1'b0; t_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_ack", 32'(t_ack), 32'h0);
            check("post_rst_dat_r", t_dat_r, 32'h0);
            @(posedge clock);
            #1;
        end
        xfer(1'b0, 32'h0000_0804, 32'h0, 4'h0, rc, ac);
        idle(1);

        // Cycle dropped during ACK: no ack, write still lands, FSM back in IDLE.
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h0000_1404;
        t_dat_w = 32'h0BAD_CAFE; t_sel = 4'hF;
        ref_mem[2][257] = 32'h0BAD_CAFE;
        @(posedge clock);
        #1;
        t_cyc = 1'b0; t_stb = 1'b0;
        @(negedge clock);
        check("abort_ack", 32'(t_ack), 32'h0);
        @(posedge clock);
        #1;
        xfer(1'b0, 32'h0000_1404, 32'h0, 4'h0, rc, ac);
        check("abort_wr_kept", t_dat_r, 32'h0BAD_CAFE);

        for (int n = 0; n < 150; n++) begin
            radr = $urandom;
            if ($urandom_range(1, 0) == 1) radr[10:2] = 9'($urandom_range(7, 0));
            xfer(1'($urandom), radr, $urandom,
                 ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom), rc, ac);
            if ($urandom_range(2, 0) != 0) idle($urandom_range(2, 1));
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
